// File: rtl/read_mem_pkg.sv
// Shared constants and state encoding for the capture-buffer readout engine.
// Included by read_mem and by any status decoder that needs the state values.
package read_mem_pkg;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_ADDR_WIDTH  = 4;
  localparam int DEF_MEMORY_SIZE = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    READ = 3'd2,
    LOAD = 3'd3,
    SEND = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/read_mem.sv
// Drains the circular capture buffer oldest-first onto a valid/ready stream.
// Optional READ_MEM_HEADER_EN: emit a sample-count beat ahead of the samples.
module read_mem
  import read_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MEMORY_SIZE = DEF_MEMORY_SIZE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic                  primed,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] raddr,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(MEMORY_SIZE);

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   raddr_reg, raddr_next;
  logic [ADDR_WIDTH:0]     remaining_reg, remaining_next;
  logic [DATA_WIDTH-1:0]   o_data_reg, o_data_next;
  logic                    o_valid_reg, o_valid_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;

`ifdef READ_MEM_HEADER_EN
  // Header beat carries the sample count, fitted to the stream width.
  logic [DATA_WIDTH-1:0]   hdr_word;
  generate
    if (DATA_WIDTH > ADDR_WIDTH + 1) begin : g_hdr_ext
      assign hdr_word = {{(DATA_WIDTH - ADDR_WIDTH - 1){1'b0}}, remaining_reg};
    end else if (DATA_WIDTH == ADDR_WIDTH + 1) begin : g_hdr_eq
      assign hdr_word = remaining_reg;
    end else begin : g_hdr_trunc
      assign hdr_word = remaining_reg[DATA_WIDTH-1:0];
    end
  endgenerate
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      raddr_reg     <= '0;
      remaining_reg <= '0;
      o_data_reg    <= '0;
      o_valid_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      raddr_reg     <= raddr_next;
      remaining_reg <= remaining_next;
      o_data_reg    <= o_data_next;
      o_valid_reg   <= o_valid_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    raddr_next     = raddr_reg;
    remaining_next = remaining_reg;
    o_data_next    = o_data_reg;
    o_valid_next   = o_valid_reg;
    busy_next      = busy_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          busy_next = 1'b1;
          // Once wrapped, the next-write slot holds the oldest sample.
          if (primed) begin
            raddr_next     = waddr;
            remaining_next = FULL_COUNT;
          end else begin
            raddr_next     = '0;
            remaining_next = {1'b0, waddr};
          end
`ifdef READ_MEM_HEADER_EN
          state_next = HDR;
`else
          if (primed || (waddr != '0)) begin
            state_next = READ;
          end else begin
            state_next = DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end
`endif
        end
      end

`ifdef READ_MEM_HEADER_EN
      HDR: begin
        o_data_next  = hdr_word;
        o_valid_next = 1'b1;
        state_next   = SEND;
      end
`endif

      READ: begin
        state_next = LOAD;
      end

      LOAD: begin
        o_data_next    = rdata;
        o_valid_next   = 1'b1;
        raddr_next     = raddr_reg + 1'b1;
        remaining_next = remaining_reg - 1'b1;
        state_next     = SEND;
      end

      SEND: begin
        if (o_ready) begin
          o_valid_next = 1'b0;
          if (remaining_reg != '0) begin
            state_next = READ;
          end else begin
            state_next = DONE;
            done_next  = 1'b1;
            busy_next  = 1'b0;
          end
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rd_en   = (state_reg == READ);
  assign raddr   = raddr_reg;
  assign o_data  = o_data_reg;
  assign o_valid = o_valid_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_read_mem.sv
// Directed bench for read_mem: queue-based stream model checked every cycle,
// plus literal expectations for latency, ordering, wrap and reset behaviour.
module tb_read_mem;
  import read_mem_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int MS = 16;
`ifdef READ_MEM_HEADER_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          primed = 1'b0;
  logic          o_ready = 1'b1;
  logic [AW-1:0] waddr = '0;
  logic          rd_en;
  logic [AW-1:0] raddr;
  logic [DW-1:0] rdata = '0;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [MS];

  int n_checks = 0;
  int n_fail = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  bit            model_active = 1'b0;
  int            done_cnt = 0;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;

  read_mem dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .waddr   (waddr),
    .primed  (primed),
    .rd_en   (rd_en),
    .raddr   (raddr),
    .rdata   (rdata),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_ready (o_ready),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Sample memory with one-cycle registered read.
  always @(posedge clk) if (rd_en) rdata <= mem[raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stream model: the queue holds every beat still owed; done is due on the
  // cycle after the queue empties, and busy covers everything before that.
  always @(negedge clk) begin
    if (reset) begin
      if (stall_prev) begin
        check("hold_valid", o_valid, 1'b1);
        check("hold_data", o_data, data_prev);
      end
      check("done", done, model_active && exp_q.size() == 0);
      check("busy", busy, model_active && exp_q.size() != 0);
      if (exp_q.size() == 0) check("valid_without_beat", o_valid, 1'b0);
      if (done) begin
        done_cnt++;
        model_active = 1'b0;
        $display("done pulse %0d", done_cnt);
      end
      if (o_valid && o_ready && exp_q.size() != 0) begin
        check("beat_data", o_data, exp_q[0]);
        $display("beat %0d data=%02h", got_q.size(), o_data);
        got_q.push_back(o_data);
        void'(exp_q.pop_front());
      end
      stall_prev = o_valid && !o_ready;
      data_prev  = o_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit p, input logic [AW-1:0] wa);
    int cnt;
    int first;
    cnt   = p ? MS : int'(wa);
    first = p ? int'(wa) : 0;
    got_q.delete();
    primed = p;
    waddr  = wa;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    // Snapshot must be taken at start; scramble the writer inputs afterwards.
    primed = ~p;
    waddr  = ~wa;
`ifdef READ_MEM_HEADER_EN
    exp_q.push_back(DW'(cnt));
`endif
    for (int k = 0; k < cnt; k++) exp_q.push_back(mem[(first + k) % MS]);
    model_active = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget && model_active; i++) tick();
    check(name, model_active, 1'b0);
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int i;
    for (i = 0; i < budget && got_q.size() < n; i++) tick();
    check(name, got_q.size() >= n, 1'b1);
  endtask

  initial begin : stim
    int d0;
    for (int i = 0; i < MS; i++) mem[i] = 8'hA0 + 8'(i);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_o_valid", o_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", rd_en, 1'b0);
    check("rst_raddr", raddr, 0);
    check("rst_o_data", o_data, 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Not primed, waddr=5: A0..A4 then done, with latency checks
    d0 = done_cnt;
    do_start(1'b0, 4'd5);
`ifndef READ_MEM_HEADER_EN
    @(negedge clk);
    check("lat_rd_en", rd_en, 1'b1);
    check("lat_raddr", raddr, 0);
    @(negedge clk);
    check("lat_valid_early", o_valid, 1'b0);
    @(negedge clk);
    check("lat_valid", o_valid, 1'b1);
    check("lat_first_data", o_data, 8'hA0);
`endif
    wait_idle(100, "t1_timeout");
    check("t1_beats", got_q.size(), 5 + H);
    check("t1_first", got_q[H], 8'hA0);
    check("t1_last", got_q[H+4], 8'hA4);
    check("t1_done_count", done_cnt - d0, 1);
    repeat (4) tick();
    check("t1_no_extra_done", done_cnt - d0, 1);

    // Primed, waddr=6: 16 samples 6..15 then 0..5
    d0 = done_cnt;
    do_start(1'b1, 4'd6);
    wait_idle(200, "t2_timeout");
    check("t2_beats", got_q.size(), 16 + H);
    check("t2_first", got_q[H], 8'hA6);
    check("t2_wrap", got_q[H+10], 8'hA0);
    check("t2_last", got_q[H+15], 8'hA5);
    check("t2_done_count", done_cnt - d0, 1);
    tick();

    // Primed, waddr=15: wrap right after the first sample
    do_start(1'b1, 4'd15);
    wait_idle(200, "t2b_timeout");
    check("t2b_first", got_q[H], 8'hAF);
    check("t2b_second", got_q[H+1], 8'hA0);
    check("t2b_last", got_q[H+15], 8'hAE);
    tick();

    // Zero samples
    d0 = done_cnt;
    do_start(1'b0, 4'd0);
`ifndef READ_MEM_HEADER_EN
    @(negedge clk);
    check("t3_done_next", done, 1'b1);
    check("t3_no_valid", o_valid, 1'b0);
`endif
    wait_idle(20, "t3_timeout");
    check("t3_beats", got_q.size(), H);
    check("t3_done_count", done_cnt - d0, 1);
    tick();

    // Backpressure for 7 cycles during sample 2
    do_start(1'b0, 4'd4);
    wait_beats(1 + H, 50, "t4_wait_first");
    o_ready = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    check("t4_stall_valid", o_valid, 1'b1);
    check("t4_stall_data", o_data, 8'hA1);
    tick();
    repeat (2) tick();
    o_ready = 1'b1;
    wait_idle(100, "t4_timeout");
    check("t4_beats", got_q.size(), 4 + H);
    check("t4_second", got_q[H+1], 8'hA1);
    check("t4_last", got_q[H+3], 8'hA3);
    tick();

    // Ignored start mid-readout, then reset during sample 3
    d0 = done_cnt;
    do_start(1'b0, 4'd5);
    wait_beats(1 + H, 50, "t5_wait_first");
    primed = 1'b1;
    waddr  = 4'd9;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    wait_beats(2 + H, 50, "t5_wait_second");
    for (int i = 0; i < 10 && !o_valid; i++) tick();
    check("t5_third_shown", o_data, 8'hA2);
    #2;
    reset = 1'b0;
    exp_q.delete();
    model_active = 1'b0;
    stall_prev = 1'b0;
    #1;
    check("t5_rst_valid", o_valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_done", done, 1'b0);
    check("t5_rst_state", 32'(dut.state_reg), 32'(IDLE));
    check("t5_second_beat", got_q[H+1], 8'hA1);
    tick();
    reset = 1'b1;
    repeat (5) tick();
    check("t5_no_done", done_cnt - d0, 0);

`ifdef READ_MEM_HEADER_EN
    // Header with three samples
    do_start(1'b0, 4'd3);
    wait_idle(60, "t6_timeout");
    check("t6_header", got_q[0], 8'h03);
    check("t6_beats", got_q.size(), 4);
    check("t6_last", got_q[3], 8'hA2);
`endif

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
